cluster_ar_arbiter: RTL
=======================

CLUSTER_AR_ARBITER -- requirements
Module: cluster_ar_arbiter

Interface
REQ-001 SHALL have parameter NrClusters, default 4, number of requesting Ara clusters (2..16).
REQ-002 SHALL have parameter AddrWidth, default 64, AR address width.
REQ-003 SHALL have parameter DataWidth, default 64, R data width.
REQ-004 SHALL have parameter MaxOutstanding, default 8, order-FIFO depth (power of two, >=2).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- slv_ar_valid_i  in  NrClusters  per-cluster AR valid.
- slv_ar_ready_o  out  NrClusters  per-cluster AR ready.
- slv_ar_addr_i  in  NrClusters*AddrWidth  per-cluster address, cluster c at slice c.
- slv_ar_len_i  in  NrClusters*8  per-cluster burst length.
- mst_ar_valid_o  out  1  AR valid to system.
- mst_ar_ready_i  in  1  AR ready from system.
- mst_ar_addr_o  out  AddrWidth  granted address.
- mst_ar_len_o  out  8  granted length.
- mst_r_valid_i  in  1  R valid from system.
- mst_r_ready_o  out  1  R ready to system.
- mst_r_data_i  in  DataWidth  R data.
- mst_r_last_i  in  1  R last.
- slv_r_valid_o  out  NrClusters  per-cluster R valid.
- slv_r_ready_i  in  NrClusters  per-cluster R ready.
- slv_r_data_o  out  DataWidth  R data, broadcast to all clusters.
- slv_r_last_o  out  1  R last, broadcast.
- stall_cnt_o  out  32  full-FIFO stall counter.

Function
REQ-006 SHALL use an FSM with states IDLE and LOCKED.
REQ-007 IDLE: if the order FIFO is not full and any slv_ar_valid_i is set, SHALL select the winner round-robin, searching from rr_ptr upward with wrap, and drive mst_ar_valid_o=1 with the winner's addr/len in the same cycle (0-cycle latency).
REQ-008 IDLE with the FIFO full SHALL force mst_ar_valid_o=0 and all slv_ar_ready_o=0.
REQ-009 slv_ar_ready_o[w] SHALL equal mst_ar_ready_i for the current winner w only; all other bits SHALL be 0.
REQ-010 On AR handshake, the FSM SHALL stay in/return to IDLE, push w into the order FIFO, and set rr_ptr=(w+1) mod NrClusters.
REQ-011 IDLE with mst_ar_valid_o=1 and mst_ar_ready_i=0 SHALL go to LOCKED and register w.
REQ-012 LOCKED SHALL keep mst_ar_valid_o=1 and addr/len from the locked cluster, ignoring other requesters, until handshake, then go to IDLE; valid SHALL never drop before handshake.
REQ-013 A requester deasserting valid while locked is an upstream protocol violation; the block SHALL NOT be required to handle it.
REQ-014 R routing, FIFO non-empty with head h: slv_r_valid_o[h]=mst_r_valid_i, other valid bits 0, and mst_r_ready_o=slv_r_ready_i[h].
REQ-015 R routing, FIFO empty: mst_r_ready_o=0 and all slv_r_valid_o=0.
REQ-016 The FIFO SHALL pop on an R handshake with mst_r_last_i=1; non-last beats SHALL NOT pop.
REQ-017 Simultaneous push and pop SHALL keep the count unchanged; push eligibility SHALL be evaluated on the pre-pop count (full blocks a grant even if a pop occurs that cycle).
REQ-018 FIFO pointers SHALL be log2(MaxOutstanding)+1 bits wide, with full/empty derived from the MSB wrap bit.
REQ-019 slv_r_data_o and slv_r_last_o SHALL be combinational copies of mst_r_data_i and mst_r_last_i.

Reset
REQ-020 On rst_i=1 at a clk_i edge: FSM=IDLE, rr_ptr=0, FIFO empty, stall_cnt_o=0.
REQ-021 Reset mid-burst SHALL discard all outstanding ordering; the system interconnect is reset concurrently.
REQ-022 While rst_i=1, mst_ar_valid_o and slv_ar_ready_o SHALL be 0 combinationally.

Configuration
REQ-023 With macro ARA_AR_ARB_PERF_EN defined, stall_cnt_o SHALL increment (saturating at 2^32-1) each cycle in IDLE where any slv_ar_valid_i=1 and the FIFO is full.
REQ-024 Without ARA_AR_ARB_PERF_EN, stall_cnt_o SHALL be constant 0 and no counter register SHALL be instantiated.

Verification
REQ-025 NrClusters=4, all valid, mst_ar_ready_i=1 -> grants 0,1,2,3,0 on consecutive cycles.
REQ-026 Cluster 2 valid with addr 0x1000, mst_ar_ready_i low 3 cycles, cluster 0 raises valid in cycle 1 -> addr 0x1000 held 4 cycles, then cluster 0 granted.
REQ-027 MaxOutstanding=8, 8 grants with no R -> 9th request sees mst_ar_valid_o=0; one R last beat -> grant next cycle; with PERF_EN, stall_cnt_o equals the number of blocked cycles.
REQ-028 Grants to clusters 1 then 3, len=3 each -> 4 beats routed to cluster 1 only, then 4 beats to cluster 3; slv_r_ready_i[1]=0 stalls mst_r_ready_o.
REQ-029 FIFO full, R last handshake and new request in the same cycle -> no grant that cycle, grant next cycle, count ends at 8.
REQ-030 rst_i asserted with 3 outstanding -> FIFO empty, mst_r_ready_o=0, rr_ptr=0 the next cycle.

Source files
------------

// File: rtl/cluster_ar_arbiter.sv
// Round-robin AR arbiter for Ara clusters sharing one AXI read port,
// with in-order R routing via a FIFO of granted cluster ids.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   slv_ar_*            per-cluster AR requests (valid/ready/addr/len)
//   mst_ar_*            single AR channel towards the system
//   mst_r_*             single R channel from the system
//   slv_r_*             per-cluster R valid/ready, broadcast data/last
//   stall_cnt_o         cycles lost to a full order FIFO
//
// Build option: define ARA_AR_ARB_PERF_EN to instantiate the stall
// counter; otherwise stall_cnt_o is tied to zero.
module cluster_ar_arbiter #(
  parameter int unsigned NrClusters     = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NrClusters-1:0]            slv_ar_valid_i,
  output logic [NrClusters-1:0]            slv_ar_ready_o,
  input  logic [NrClusters*AddrWidth-1:0]  slv_ar_addr_i,
  input  logic [NrClusters*8-1:0]          slv_ar_len_i,
  output logic                             mst_ar_valid_o,
  input  logic                             mst_ar_ready_i,
  output logic [AddrWidth-1:0]             mst_ar_addr_o,
  output logic [7:0]                       mst_ar_len_o,
  input  logic                             mst_r_valid_i,
  output logic                             mst_r_ready_o,
  input  logic [DataWidth-1:0]             mst_r_data_i,
  input  logic                             mst_r_last_i,
  output logic [NrClusters-1:0]            slv_r_valid_o,
  input  logic [NrClusters-1:0]            slv_r_ready_i,
  output logic [DataWidth-1:0]             slv_r_data_o,
  output logic                             slv_r_last_o,
  output logic [31:0]                      stall_cnt_o
);

  localparam int unsigned IdxW = $clog2(NrClusters);
  localparam int unsigned PtrW = $clog2(MaxOutstanding) + 1;
  localparam int unsigned AW   = PtrW - 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] lock_q, lock_d;
  logic [IdxW-1:0] rr_win;
  logic [IdxW-1:0] win;
  logic            rr_found;
  logic            ar_hs;

  logic [PtrW-1:0] wr_q, rd_q;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [IdxW-1:0] head;
  logic            full, empty;
  logic            push, pop;

  // Wrap bit differs and index bits match: the FIFO has lapped.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PtrW-1] != rd_q[PtrW-1]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // Round-robin search starting at rr_q, wrapping at NrClusters.
  always_comb begin
    logic [IdxW:0] cand;
    rr_win   = rr_q;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 0; i < NrClusters; i++) begin
      cand = {1'b0, rr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NrClusters)) begin
        cand = cand - (IdxW+1)'(NrClusters);
      end
      if (!rr_found && slv_ar_valid_i[cand[IdxW-1:0]]) begin
        rr_found = 1'b1;
        rr_win   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    lock_d         = lock_q;
    rr_d           = rr_q;
    win            = rr_win;
    mst_ar_valid_o = 1'b0;
    ar_hs          = 1'b0;

    unique case (state_q)
      IDLE: begin
        win            = rr_win;
        mst_ar_valid_o = rr_found && !full;
      end
      LOCKED: begin
        win            = lock_q;
        mst_ar_valid_o = 1'b1;
      end
      default: ;
    endcase

    if (rst_i) begin
      mst_ar_valid_o = 1'b0;
    end

    ar_hs = mst_ar_valid_o && mst_ar_ready_i;

    // An offered request either completes now or is held
    // against the same cluster until the system accepts it.
    if (mst_ar_valid_o) begin
      if (ar_hs) begin
        state_d = IDLE;
        if (win == IdxW'(NrClusters - 1)) begin
          rr_d = '0;
        end else begin
          rr_d = win + 1'b1;
        end
      end else begin
        state_d = LOCKED;
        lock_d  = win;
      end
    end
  end

  always_comb begin
    slv_ar_ready_o = '0;
    if (mst_ar_valid_o) begin
      slv_ar_ready_o[win] = mst_ar_ready_i;
    end
  end

  assign mst_ar_addr_o = slv_ar_addr_i[win*AddrWidth +: AddrWidth];
  assign mst_ar_len_o  = slv_ar_len_i[win*8 +: 8];

  assign head = fifo_q[rd_q[AW-1:0]];
  assign push = ar_hs;
  assign pop  = !empty && mst_r_valid_i &&
                mst_r_ready_o && mst_r_last_i;

  always_comb begin
    slv_r_valid_o = '0;
    mst_r_ready_o = 1'b0;
    if (!empty) begin
      slv_r_valid_o[head] = mst_r_valid_i;
      mst_r_ready_o       = slv_r_ready_i[head];
    end
  end

  assign slv_r_data_o = mst_r_data_i;
  assign slv_r_last_o = mst_r_last_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      if (push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_q[AW-1:0]] <= win;
    end
  end

`ifdef ARA_AR_ARB_PERF_EN
  logic [31:0] stall_q;
  logic        stall_hit;

  assign stall_hit = (state_q == IDLE) &&
                     (|slv_ar_valid_i) && full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (stall_hit && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
